// File: rtl/uart.sv
// UART loopback: a transmitter serializes 7 data bits plus even parity onto an
// internal serial line, and a receiver on that line rebuilds {parity, data}.
//
// TX state | meaning
// ---------+-------------------------------------------------------
// TX_IDLE  | line held at 1, waiting for in_ready
// TX_START | driving the start bit (0)
// TX_DATA  | driving d0..d6, LSB first
// TX_PARITY| driving the even-parity bit
// TX_STOP  | driving the stop bit (1)
//
// RX state | meaning
// ---------+-------------------------------------------------------
// RX_IDLE  | waiting for the line to fall
// RX_START | waiting for the middle of the start bit to confirm it
// RX_DATA  | sampling d0..d6 at each bit centre
// RX_PARITY| sampling the parity bit
// RX_STOP  | sampling the stop bit; a good stop publishes the frame
module uart #(
    parameter int CLKS_PER_BIT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] data_in,
    input  logic       in_ready,
    output logic [7:0] data_out,
    output logic       out_valid
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [2:0]       LAST_IDX  = 3'd6;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    // Serial line between TX and RX; idles high.
    logic             line, line_n;

    tx_state_t        tx_state, tx_state_n;
    logic [CNT_W-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]       tx_idx, tx_idx_n;
    logic [6:0]       tx_data, tx_data_n;
    logic             tx_par, tx_par_n;

    rx_state_t        rx_state, rx_state_n;
    logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]       rx_idx, rx_idx_n;
    logic [6:0]       rx_data, rx_data_n;
    logic             rx_par, rx_par_n;
    logic [7:0]       data_out_n;
    logic             out_valid_n;

    // TX and RX state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            line      <= 1'b1;
            tx_state  <= TX_IDLE;
            tx_cnt    <= '0;
            tx_idx    <= '0;
            tx_data   <= '0;
            tx_par    <= 1'b0;
            rx_state  <= RX_IDLE;
            rx_cnt    <= '0;
            rx_idx    <= '0;
            rx_data   <= '0;
            rx_par    <= 1'b0;
            data_out  <= 8'h00;
            out_valid <= 1'b0;
        end else begin
            line      <= line_n;
            tx_state  <= tx_state_n;
            tx_cnt    <= tx_cnt_n;
            tx_idx    <= tx_idx_n;
            tx_data   <= tx_data_n;
            tx_par    <= tx_par_n;
            rx_state  <= rx_state_n;
            rx_cnt    <= rx_cnt_n;
            rx_idx    <= rx_idx_n;
            rx_data   <= rx_data_n;
            rx_par    <= rx_par_n;
            data_out  <= data_out_n;
            out_valid <= out_valid_n;
        end
    end

    // TX next state: each bit lasts until the down-counter reaches zero; a
    // request seen at the end of the stop bit chains straight into a new frame.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_idx_n   = tx_idx;
        tx_data_n  = tx_data;
        tx_par_n   = tx_par;
        line_n     = line;
        unique case (tx_state)
            TX_IDLE: begin
                line_n = 1'b1;
                if (in_ready) begin
                    tx_state_n = TX_START;
                    tx_cnt_n   = BIT_LAST;
                    tx_data_n  = data_in;
                    tx_par_n   = ^data_in;
                    line_n     = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt == '0) begin
                    tx_state_n = TX_DATA;
                    tx_cnt_n   = BIT_LAST;
                    tx_idx_n   = 3'd0;
                    line_n     = tx_data[0];
                    tx_data_n  = {1'b0, tx_data[6:1]};
                end else begin
                    tx_cnt_n = tx_cnt - CNT_ONE;
                end
            end
            TX_DATA: begin
                if (tx_cnt == '0) begin
                    tx_cnt_n = BIT_LAST;
                    if (tx_idx == LAST_IDX) begin
                        tx_state_n = TX_PARITY;
                        line_n     = tx_par;
                    end else begin
                        tx_idx_n  = tx_idx + 3'd1;
                        line_n    = tx_data[0];
                        tx_data_n = {1'b0, tx_data[6:1]};
                    end
                end else begin
                    tx_cnt_n = tx_cnt - CNT_ONE;
                end
            end
            TX_PARITY: begin
                if (tx_cnt == '0) begin
                    tx_state_n = TX_STOP;
                    tx_cnt_n   = BIT_LAST;
                    line_n     = 1'b1;
                end else begin
                    tx_cnt_n = tx_cnt - CNT_ONE;
                end
            end
            TX_STOP: begin
                if (tx_cnt == '0) begin
                    if (in_ready) begin
                        tx_state_n = TX_START;
                        tx_cnt_n   = BIT_LAST;
                        tx_data_n  = data_in;
                        tx_par_n   = ^data_in;
                        line_n     = 1'b0;
                    end else begin
                        tx_state_n = TX_IDLE;
                        line_n     = 1'b1;
                    end
                end else begin
                    tx_cnt_n = tx_cnt - CNT_ONE;
                end
            end
            default: begin
                tx_state_n = TX_IDLE;
                tx_cnt_n   = '0;
                line_n     = 1'b1;
            end
        endcase
    end

    // RX next state: the first wait is half a bit so every later sample lands
    // mid-bit; a low stop bit drops the frame without touching data_out.
    always_comb begin
        rx_state_n  = rx_state;
        rx_cnt_n    = rx_cnt;
        rx_idx_n    = rx_idx;
        rx_data_n   = rx_data;
        rx_par_n    = rx_par;
        data_out_n  = data_out;
        out_valid_n = 1'b0;
        unique case (rx_state)
            RX_IDLE: begin
                if (!line) begin
                    rx_state_n = RX_START;
                    rx_cnt_n   = HALF_LAST;
                    rx_idx_n   = 3'd0;
                end
            end
            RX_START: begin
                if (rx_cnt == '0) begin
                    if (line) begin
                        rx_state_n = RX_IDLE;
                    end else begin
                        rx_state_n = RX_DATA;
                        rx_cnt_n   = BIT_LAST;
                        rx_idx_n   = 3'd0;
                    end
                end else begin
                    rx_cnt_n = rx_cnt - CNT_ONE;
                end
            end
            RX_DATA: begin
                if (rx_cnt == '0) begin
                    rx_cnt_n  = BIT_LAST;
                    rx_data_n = {line, rx_data[6:1]};
                    if (rx_idx == LAST_IDX) begin
                        rx_state_n = RX_PARITY;
                    end else begin
                        rx_idx_n = rx_idx + 3'd1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt - CNT_ONE;
                end
            end
            RX_PARITY: begin
                if (rx_cnt == '0) begin
                    rx_state_n = RX_STOP;
                    rx_cnt_n   = BIT_LAST;
                    rx_par_n   = line;
                end else begin
                    rx_cnt_n = rx_cnt - CNT_ONE;
                end
            end
            RX_STOP: begin
                if (rx_cnt == '0) begin
                    rx_state_n = RX_IDLE;
                    if (line) begin
                        data_out_n  = {rx_par, rx_data};
                        out_valid_n = 1'b1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt - CNT_ONE;
                end
            end
            default: begin
                rx_state_n = RX_IDLE;
                rx_cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart.sv
// Directed bench for the UART loopback with the default CLKS_PER_BIT of 2.
module tb_uart;

    logic       clk;
    logic       rst;
    logic [6:0] data_in;
    logic       in_ready;
    logic [7:0] data_out;
    logic       out_valid;

    int checks;
    int failures;

    uart dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .in_ready (in_ready),
        .data_out (data_out),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one accepting edge (E0) with the caller's in_ready/data_in, then
    // watches ncyc edges, recording up to two out_valid pulses (offset from E0).
    task automatic run_frame(input int ncyc, input int drop_at, input int chg_at,
                             input logic [6:0] chg_val, input int pulse_at,
                             output int npulse, output int t0, output logic [7:0] d0,
                             output int t1, output logic [7:0] d1);
        npulse = 0;
        t0 = -1; t1 = -1;
        d0 = 8'h00; d1 = 8'h00;
        for (int off = 0; off <= ncyc; off++) begin
            tick();
            if (off > 0 && out_valid) begin
                if (npulse == 0) begin t0 = off; d0 = data_out; end
                else if (npulse == 1) begin t1 = off; d1 = data_out; end
                npulse++;
            end
            if (off == drop_at) in_ready = 1'b0;
            if (off == chg_at) data_in = chg_val;
            if (pulse_at > 0 && off == pulse_at - 1) begin
                in_ready = 1'b1;
                data_in  = 7'h55;
            end
            if (pulse_at > 0 && off == pulse_at) in_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_ready = 1'b1;
        data_in = 7'h7F;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_out_valid cycle %0d: got %b want 0", i, out_valid);
            end
            checks++;
            if (data_out !== 8'h00) begin
                failures++;
                $display("FAIL reset_data_out cycle %0d: got %h want 00", i, data_out);
            end
            checks++;
            if (dut.line !== 1'b1) begin
                failures++;
                $display("FAIL reset_line cycle %0d: got %b want 1", i, dut.line);
            end
        end
        in_ready = 1'b0;
        rst = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_single_frame();
        int n, t0, t1;
        logic [7:0] d0, d1;
        data_in = 7'b1101101;
        in_ready = 1'b1;
        run_frame(45, 1, -1, 7'h00, 0, n, t0, d0, t1, d1);
        checks++;
        if (n !== 1) begin failures++; $display("FAIL single_pulses: got %0d want 1", n); end
        checks++;
        if (t0 !== 20) begin failures++; $display("FAIL single_latency: got %0d want 20", t0); end
        checks++;
        if (d0 !== 8'hED) begin failures++; $display("FAIL single_data: got %h want ed", d0); end
    endtask

    task automatic test_second_frame();
        int n, t0, t1;
        logic [7:0] d0, d1;
        repeat (10) tick();
        checks++;
        if (data_out !== 8'hED) begin
            failures++;
            $display("FAIL hold_data_out: got %h want ed", data_out);
        end
        data_in = 7'b0101010;
        in_ready = 1'b1;
        run_frame(45, 0, -1, 7'h00, 0, n, t0, d0, t1, d1);
        checks++;
        if (n !== 1) begin failures++; $display("FAIL second_pulses: got %0d want 1", n); end
        checks++;
        if (t0 !== 20) begin failures++; $display("FAIL second_latency: got %0d want 20", t0); end
        checks++;
        if (d0 !== 8'hAA) begin failures++; $display("FAIL second_data: got %h want aa", d0); end
    endtask

    task automatic test_back_to_back();
        int n, t0, t1;
        logic [7:0] d0, d1;
        data_in = 7'h00;
        in_ready = 1'b1;
        run_frame(55, 20, 1, 7'h7F, 0, n, t0, d0, t1, d1);
        checks++;
        if (n !== 2) begin failures++; $display("FAIL b2b_pulses: got %0d want 2", n); end
        checks++;
        if (t0 !== 20) begin failures++; $display("FAIL b2b_first_latency: got %0d want 20", t0); end
        checks++;
        if (d0 !== 8'h00) begin failures++; $display("FAIL b2b_first_data: got %h want 00", d0); end
        checks++;
        if (t1 !== 40) begin failures++; $display("FAIL b2b_second_latency: got %0d want 40", t1); end
        checks++;
        if (d1 !== 8'hFF) begin failures++; $display("FAIL b2b_second_data: got %h want ff", d1); end
    endtask

    task automatic test_busy_ignore();
        int n, t0, t1;
        logic [7:0] d0, d1;
        data_in = 7'h0F;
        in_ready = 1'b1;
        run_frame(45, 0, -1, 7'h00, 5, n, t0, d0, t1, d1);
        checks++;
        if (n !== 1) begin failures++; $display("FAIL busy_pulses: got %0d want 1", n); end
        checks++;
        if (t0 !== 20) begin failures++; $display("FAIL busy_latency: got %0d want 20", t0); end
        checks++;
        if (d0 !== 8'h0F) begin failures++; $display("FAIL busy_data: got %h want 0f", d0); end
    endtask

    task automatic test_reset_mid_frame();
        int n, t0, t1, seen;
        logic [7:0] d0, d1;
        data_in = 7'h12;
        in_ready = 1'b1;
        tick();
        in_ready = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (dut.line !== 1'b1) begin failures++; $display("FAIL midrst_line: got %b want 1", dut.line); end
        checks++;
        if (data_out !== 8'h00) begin failures++; $display("FAIL midrst_data_out: got %h want 00", data_out); end
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin failures++; $display("FAIL midrst_no_pulse: got %0d pulses want 0", seen); end
        data_in = 7'h4B;
        in_ready = 1'b1;
        run_frame(30, 0, -1, 7'h00, 0, n, t0, d0, t1, d1);
        checks++;
        if (n !== 1) begin failures++; $display("FAIL post_rst_pulses: got %0d want 1", n); end
        checks++;
        if (t0 !== 20) begin failures++; $display("FAIL post_rst_latency: got %0d want 20", t0); end
        checks++;
        if (d0 !== 8'h4B) begin failures++; $display("FAIL post_rst_data: got %h want 4b", d0); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        in_ready = 1'b0;
        data_in = 7'h00;
        test_reset();
        test_single_frame();
        test_second_frame();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
